// File: rtl/ad_da_pkg.sv
// Shared defaults and FSM state type for the ADC buffer reader.
// Imported by adc_buf_reader and rd_skid_fifo.
package ad_da_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2048;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FULL,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry output FIFO holding {last, data} read from the capture buffer.
// Ports: push/push_data in, pop in, valid/head out, count out, flush clears.
module rd_skid_fifo
  import ad_da_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid = (count != 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/adc_buf_reader.sv
// Reads one captured ADC frame out of the buffer into a valid/ready stream.
// Ports: start/abort/buf_full ctl, rd_en/rd_addr/rd_data buffer, m_* stream, busy/done.
module adc_buf_reader
  import ad_da_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              buf_full,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic              in_flight;
  logic              in_flight_last;
  logic              at_last;
  logic              pop;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;
  logic [DATA_W:0]   head;
  logic              drained;

  assign at_last = (rd_addr == ADDR_W'(DEPTH - 1));
  assign pop     = fifo_valid & m_ready;
  assign occ     = {1'b0, fifo_count} + {2'b0, in_flight};

  // A slot leaving this cycle counts as free, so a full-rate
  // stream keeps one sample queued and one read in flight.
  assign rd_en = (state == READ) && !abort &&
                 (occ < (3'd2 + {2'b0, pop}));

  // Empty after this edge: nothing in flight, FIFO empty or
  // its only sample leaving now.
  assign drained = !in_flight &&
                   ((fifo_count == 2'd0) ||
                    ((fifo_count == 2'd1) && pop));

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = WAIT_FULL;
      WAIT_FULL: if (buf_full) state_nxt = READ;
      READ:      if (rd_en && at_last) state_nxt = DRAIN;
      DRAIN:     if (drained) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr        <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= rd_en;
      in_flight_last <= rd_en & at_last;
      if (abort || state == IDLE) begin
        rd_addr <= '0;
      end else if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  rd_skid_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk       (adc_clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (in_flight & ~abort),
    .push_data ({in_flight_last, rd_data}),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign m_valid = fifo_valid;
  assign m_data  = head[DATA_W-1:0];
  assign m_last  = fifo_valid & head[DATA_W];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE) & ~abort;

endmodule

// File: tb/tb_adc_buf_reader.sv
// Directed bench for adc_buf_reader: full frames, stalls, abort, reset.
// Buffer model returns the low byte of the address one cycle after rd_en.
module tb_adc_buf_reader;

  logic        adc_clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        buf_full;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int n_xfer, data_err, last_err, stab_err, addr_err;
  int done_cnt, max_cnt, first_rd, first_valid;
  int done_cyc, last_xfer, rd_early, post_ab_err;
  int rst_err, exp_addr, rise_cyc;
  bit timed_out, ab_checked, drain_started, rst_hit;

  adc_buf_reader u_dut (
    .adc_clk  (adc_clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .buf_full (buf_full),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  always @(posedge adc_clk) cyc <= cyc + 1;

  always @(posedge adc_clk) begin
    if (rd_en) rd_data <= rd_addr[7:0];
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit outs_zero();
    return (rd_en === 1'b0) && (rd_addr === '0) &&
           (m_valid === 1'b0) && (m_data === '0) &&
           (m_last === 1'b0) && (busy === 1'b0) &&
           (done === 1'b0);
  endfunction

  task automatic run_frame(input int pct,
                           input int abort_at,
                           input int full_delay,
                           input bit drain_start,
                           input int rst_at);
    bit fin, ab_pend, prev_stall, last_rd_seen;
    int tail, waited, cnt;
    logic [7:0] prev_data;
    logic [7:0] exp_d;
    n_xfer = 0; data_err = 0; last_err = 0; stab_err = 0;
    addr_err = 0; done_cnt = 0; max_cnt = 0; first_rd = -1;
    first_valid = -1; done_cyc = -1; last_xfer = -1;
    rd_early = 0; post_ab_err = 0; rst_err = 0; exp_addr = 0;
    rise_cyc = -1; timed_out = 0; ab_checked = 0;
    drain_started = 0; rst_hit = 0;
    fin = 0; ab_pend = 0; prev_stall = 0; last_rd_seen = 0;
    tail = -1; waited = 0; prev_data = '0;
    @(negedge adc_clk);
    start = 1'b1;
    abort = 1'b0;
    m_ready = 1'b0;
    buf_full = (full_delay == 0);
    if (full_delay == 0) rise_cyc = cyc;
    for (int t = 0; t < 20000 && !fin; t++) begin
      @(negedge adc_clk);
      start = 1'b0;
      abort = 1'b0;
      if (full_delay > 0) begin
        if (waited == full_delay) begin
          buf_full = 1'b1;
          rise_cyc = cyc;
        end
        waited++;
      end
      m_ready = ($urandom_range(99) < pct);
      if (drain_start && last_rd_seen && !drain_started) begin
        start = 1'b1;
        drain_started = 1;
      end
      if (abort_at >= 0 && !ab_pend && !ab_checked &&
          n_xfer == abort_at) begin
        abort = 1'b1;
        m_ready = 1'b0;
      end
      if (rst_at >= 0 && n_xfer == rst_at) begin
        rst_hit = 1;
        rst_n = 1'b0;
        m_ready = 1'b0;
        #1;
        if (!outs_zero()) rst_err++;
        repeat (3) begin
          @(negedge adc_clk);
          #1;
          if (!outs_zero()) rst_err++;
        end
        rst_n = 1'b1;
        fin = 1;
      end else begin
        #1;
        if (ab_pend) begin
          if (m_valid !== 1'b0 || busy !== 1'b0) post_ab_err++;
          ab_pend = 0;
          ab_checked = 1;
          tail = 10;
        end
        if (rd_en === 1'b1) begin
          if (first_rd < 0) first_rd = cyc;
          if (rd_addr !== exp_addr[10:0]) addr_err++;
          if (!buf_full) rd_early++;
          if (rd_addr == 11'd2047) last_rd_seen = 1;
          exp_addr++;
        end
        cnt = int'(u_dut.fifo_count);
        if (cnt > max_cnt) max_cnt = cnt;
        if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data))
          stab_err++;
        if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (m_valid === 1'b1 && m_ready) begin
          exp_d = n_xfer[7:0];
          if (m_data !== exp_d) data_err++;
          if (m_last !== (n_xfer == 2047)) last_err++;
          last_xfer = cyc;
          n_xfer++;
        end
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_data = m_data;
        if (done === 1'b1) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
          if (tail < 0) tail = 8;
        end
        if (abort) ab_pend = 1;
        if (tail == 0) fin = 1;
        else if (tail > 0) tail--;
      end
    end
    if (!fin) timed_out = 1;
    @(negedge adc_clk);
    start = 1'b0;
    abort = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    buf_full = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge adc_clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fifo_count", u_dut.fifo_count, 0);
    @(negedge adc_clk);
    rst_n = 1'b1;

    // start and abort together in IDLE: abort wins
    @(negedge adc_clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge adc_clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("start_abort_busy", busy, 0);

    // (a) full-rate frame
    run_frame(100, -1, 0, 0, -1);
    chk("a_timeout", timed_out, 0);
    chk("a_xfers", n_xfer, 2048);
    chk("a_data_err", data_err, 0);
    chk("a_last_err", last_err, 0);
    chk("a_addr_err", addr_err, 0);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_first_valid_lat", first_valid - first_rd, 2);
    chk("a_stream_span", last_xfer - first_valid, 2047);
    // edges from the one capturing the first read to the one raising done
    chk("a_done_lat_ok", (done_cyc - first_rd - 1) <= 2049, 1);
    chk("a_addr_wrap", rd_addr, 0);
    chk("a_busy_after", busy, 0);

    // (b) buf_full held low for 50 cycles
    run_frame(100, -1, 50, 0, -1);
    chk("b_timeout", timed_out, 0);
    chk("b_rd_before_full", rd_early, 0);
    chk("b_first_rd_lat", first_rd - rise_cyc, 1);
    chk("b_xfers", n_xfer, 2048);
    chk("b_done_cnt", done_cnt, 1);
    buf_full = 1'b1;

    // (c) 30% ready duty
    run_frame(30, -1, 0, 0, -1);
    chk("c_timeout", timed_out, 0);
    chk("c_xfers", n_xfer, 2048);
    chk("c_data_err", data_err, 0);
    chk("c_last_err", last_err, 0);
    chk("c_stable_err", stab_err, 0);
    chk("c_max_count_ok", max_cnt <= 2, 1);
    chk("c_done_cnt", done_cnt, 1);

    // (d) abort at transfer 100, then a clean frame
    run_frame(100, 100, 0, 0, -1);
    chk("d_abort_seen", ab_checked, 1);
    chk("d_post_abort", post_ab_err, 0);
    chk("d_xfers", n_xfer, 100);
    chk("d_no_done", done_cnt, 0);
    run_frame(100, -1, 0, 0, -1);
    chk("d2_addr_err", addr_err, 0);
    chk("d2_xfers", n_xfer, 2048);
    chk("d2_data_err", data_err, 0);
    chk("d2_done_cnt", done_cnt, 1);

    // (e) reset mid-READ, then a full frame
    run_frame(100, -1, 0, 0, 300);
    chk("e_rst_hit", rst_hit, 1);
    chk("e_rst_outs", rst_err, 0);
    run_frame(100, -1, 0, 0, -1);
    chk("e2_xfers", n_xfer, 2048);
    chk("e2_data_err", data_err, 0);
    chk("e2_last_err", last_err, 0);
    chk("e2_done_cnt", done_cnt, 1);

    // (f) start during DRAIN is ignored
    run_frame(100, -1, 0, 1, -1);
    chk("f_start_sent", drain_started, 1);
    chk("f_xfers", n_xfer, 2048);
    chk("f_done_cnt", done_cnt, 1);
    chk("f_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_buf_reader.md
ADC_BUF_READER -- requirements
Module: adc_buf_reader

Interface
REQ-001 Parameter ADDR_W, default 11, is the capture buffer address width.
REQ-002 Parameter DATA_W, default 8, is the buffer sample width.
REQ-003 Parameter DEPTH, default 2048, is the number of samples per frame and SHALL equal 2**ADDR_W.
REQ-004 One clock and an asynchronous active-low reset: adc_clk and rst_n.
REQ-005 adc_clk  in  1  ADC processing clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to read one frame; honoured only in IDLE.
REQ-008 abort  in  1  synchronous cancel of the current read.
REQ-009 buf_full  in  1  level from the capture writer: the frame in the buffer is complete.
REQ-010 rd_en  out  1  buffer read strobe.
REQ-011 rd_addr  out  ADDR_W  buffer read address.
REQ-012 rd_data  in  DATA_W  buffer read data, valid exactly one cycle after rd_en.
REQ-013 m_valid  out  1  output sample valid.
REQ-014 m_ready  in  1  downstream accept.
REQ-015 m_data  out  DATA_W  output sample.
REQ-016 m_last  out  1  marks the sample read from address DEPTH-1.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when a frame is fully delivered.

Function
REQ-019 The FSM SHALL have the states IDLE, WAIT_FULL, READ, DRAIN and DONE.
REQ-020 IDLE -> WAIT_FULL on start; WAIT_FULL -> READ on the first cycle buf_full=1, with rd_addr=0.
REQ-021 In READ, rd_en SHALL be asserted only when (FIFO occupancy + reads in flight) < 2; rd_addr SHALL increment by 1 after each rd_en.
REQ-022 rd_data SHALL be written into a 2-entry output FIFO on the edge after its rd_en; no sample is ever dropped or duplicated.
REQ-023 After rd_en at address DEPTH-1 the FSM SHALL enter DRAIN; rd_en stays 0 and rd_addr SHALL wrap to 0.
REQ-024 DRAIN -> DONE when the FIFO is empty and no read is in flight; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-025 A transfer SHALL occur when m_valid=1 and m_ready=1; m_valid and m_data SHALL hold stable while m_ready=0.
REQ-026 With m_ready held at 1, throughput SHALL be 1 sample/cycle, and the first m_valid SHALL appear 2 cycles after the first rd_en.
REQ-027 m_last SHALL be 1 only with the sample from address DEPTH-1; exactly DEPTH transfers SHALL occur per frame.
REQ-028 A deassertion of buf_full after WAIT_FULL SHALL be ignored for the current frame.
REQ-029 start outside IDLE SHALL be ignored; when start and abort occur in the same cycle in IDLE, abort wins.
REQ-030 abort in any state SHALL return the FSM to IDLE on the next edge: flush the FIFO, discard in-flight data, m_valid=0, and no done pulse.

Reset
REQ-031 While rst_n=0: state=IDLE; rd_en, rd_addr, m_valid, m_data, m_last, busy and done all 0; FIFO empty.
REQ-032 Reset mid-frame SHALL behave like abort, and no output SHALL glitch high on release.

Structure
REQ-033 Package ad_da_pkg SHALL hold the default ADDR_W, DATA_W and DEPTH and the FSM state enum.
REQ-034 The 2-entry output FIFO SHALL be a sub-module named rd_skid_fifo, which exposes its count.

Verification
REQ-035 Bench stimulus (a): DEPTH=2048 RAM model with mem[i]=i[7:0], buf_full=1, m_ready=1, start pulse. Required response: 2048 transfers in order 0..255 repeating, m_last only on the 2048th transfer, one done pulse, and 2049 cycles from first rd_en to done or fewer.
REQ-036 Bench stimulus (b): start with buf_full=0 for 50 cycles, then 1. Required response: rd_en stays 0 throughout the wait, and the first rd_en comes 1 cycle after buf_full rises.
REQ-037 Bench stimulus (c): random m_ready at 30% duty. Required response: the data sequence is identical to (a), m_data is stable while stalled, and FIFO count never exceeds 2.
REQ-038 Bench stimulus (d): abort at transfer 100. Required response: m_valid=0 next cycle, busy=0, no done; a following start re-reads from address 0.
REQ-039 Bench stimulus (e): rst_n pulsed low mid-READ, then start re-issued. Required response: all outputs 0 during reset, and the full frame of (a) is delivered afterwards.
REQ-040 Bench stimulus (f): start issued during DRAIN. Required response: start is ignored, and exactly one done pulse occurs.
